// File: rtl/pixel_pkg.sv
// Shared types and default geometry for the pixel generator / word packer pair.
package pixel_pkg;

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} packer_state_t;

  localparam int unsigned PIX_W        = 8;
  localparam int unsigned PIX_PER_WORD = 4;
  localparam int unsigned H_PIXELS     = 640;
  localparam int unsigned V_LINES      = 480;

endpackage

// File: rtl/pixel_word_packer_if.sv
// Packed-word output stream: word plus line/frame tags, valid/ready handshake.
interface pixel_word_packer_if #(
  parameter int unsigned WORD_W = 32
);

  logic [WORD_W-1:0] out_data;
  logic              out_eol;
  logic              out_eof;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out_data,
    output out_eol,
    output out_eof,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_eol,
    input  out_eof,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/word_fifo2.sv
// Two-entry synchronous FIFO; caller must not push when full unless also popping.
module word_fifo2 #(
  parameter int unsigned WIDTH = 34
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_pop;

  assign do_pop   = pop & ~empty;
  assign full     = (count_q == 2'd2);
  assign empty    = (count_q == 2'd0);
  assign pop_data = mem_q[rd_ptr_q];

  // When full, wr_ptr equals rd_ptr: a simultaneous push overwrites the slot being popped.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      unique case ({push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/pixel_word_packer.sv
// Packs pixel-tick samples into words for one frame, tagging end-of-line and end-of-frame.
module pixel_word_packer
  import pixel_pkg::*;
#(
  parameter int unsigned PIX_W        = pixel_pkg::PIX_W,
  parameter int unsigned PIX_PER_WORD = pixel_pkg::PIX_PER_WORD,
  parameter int unsigned H_PIXELS     = pixel_pkg::H_PIXELS,
  parameter int unsigned V_LINES      = pixel_pkg::V_LINES
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       flag_pixel,
  input  logic [PIX_W-1:0]           pixel_in,
  input  logic                       start_frame,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       overrun,
  pixel_word_packer_if.master        stream
);

  localparam int unsigned WORD_W = PIX_W * PIX_PER_WORD;
  localparam int unsigned PC_W   = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam int unsigned COL_W  = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int unsigned ROW_W  = (V_LINES > 1) ? $clog2(V_LINES) : 1;

  typedef logic [PIX_PER_WORD-1:0][PIX_W-1:0] pack_t;

  packer_state_t state_q, state_d;
  logic          flag_prev_q;
  logic [PC_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  pack_t         pack_q, pack_d, word_next;
  logic          overrun_q, overrun_d;

  logic tick, last_pix, last_col, last_row;
  logic word_push;
  logic fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [WORD_W+1:0] fifo_din, fifo_dout;

  assign tick     = flag_pixel ^ flag_prev_q;
  assign last_pix = (pix_cnt_q == PC_W'(PIX_PER_WORD - 1));
  assign last_col = (col_q == COL_W'(H_PIXELS - 1));
  assign last_row = (row_q == ROW_W'(V_LINES - 1));

  assign fifo_pop  = stream.out_valid & stream.out_ready;
  // A full buffer only accepts the word if the head leaves in the same cycle.
  assign fifo_push = word_push & (~fifo_full | fifo_pop);
  assign fifo_din  = {last_col & last_row, last_col, word_next};

  assign busy    = (state_q != IDLE);
  assign overrun = overrun_q;

  assign {stream.out_eof, stream.out_eol, stream.out_data} = fifo_dout;
  assign stream.out_valid = ~fifo_empty;

  always_comb begin
    state_d    = state_q;
    pix_cnt_d  = pix_cnt_q;
    col_d      = col_q;
    row_d      = row_q;
    pack_d     = pack_q;
    overrun_d  = overrun_q;
    word_push  = 1'b0;
    frame_done = 1'b0;
    word_next  = pack_q;
    word_next[pix_cnt_q] = pixel_in;

    unique case (state_q)
      IDLE: begin
        if (start_frame) begin
          state_d   = ACTIVE;
          pix_cnt_d = '0;
          col_d     = '0;
          row_d     = '0;
          overrun_d = 1'b0;
        end
      end
      ACTIVE: begin
        if (tick) begin
          pack_d = word_next;
          if (last_pix) begin
            pix_cnt_d = '0;
            word_push = 1'b1;
          end else begin
            pix_cnt_d = pix_cnt_q + 1'b1;
          end
          if (last_col) begin
            col_d = '0;
            row_d = last_row ? '0 : row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
          if (last_pix && last_col && last_row) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (fifo_empty) begin
          state_d    = IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (word_push && !fifo_push) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      flag_prev_q <= 1'b0;
      pix_cnt_q   <= '0;
      col_q       <= '0;
      row_q       <= '0;
      pack_q      <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flag_prev_q <= flag_pixel;
      pix_cnt_q   <= pix_cnt_d;
      col_q       <= col_d;
      row_q       <= row_d;
      pack_q      <= pack_d;
      overrun_q   <= overrun_d;
    end
  end

  word_fifo2 #(
    .WIDTH (WORD_W + 2)
  ) u_fifo (
    .clk       (clk),
    .n_rst     (n_rst),
    .push      (fifo_push),
    .push_data (fifo_din),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_pixel_word_packer.sv
// Bench for pixel_word_packer: random pixels against a queue-level frame/buffer model.
module tb_pixel_word_packer;

  localparam int PW    = 8;
  localparam int PPW   = 4;
  localparam int H     = 8;
  localparam int V     = 2;
  localparam int NPIX  = H * V;
  localparam int WW    = PW * PPW;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          flag_pixel = 1'b0;
  logic [PW-1:0] pixel_in = '0;
  logic          start_frame = 1'b0;
  logic          busy, frame_done, overrun;

  pixel_word_packer_if #(.WORD_W(WW)) bus ();

  pixel_word_packer #(
    .PIX_W        (PW),
    .PIX_PER_WORD (PPW),
    .H_PIXELS     (H),
    .V_LINES      (V)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .flag_pixel  (flag_pixel),
    .pixel_in    (pixel_in),
    .start_frame (start_frame),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun     (overrun),
    .stream      (bus.master)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: frame = NPIX ticks; every PPW pixels form a word; 2-deep buffer.
  logic          m_prev = 1'b0;
  bit            m_active = 1'b0;
  bit            m_done = 1'b0;
  bit            m_ovr = 1'b0;
  int            m_n = 0;
  logic [PW-1:0] m_cur[$];
  logic [WW+1:0] m_q[$];

  logic [WW+1:0] rx[$];
  int            fd_cnt = 0;
  logic [PW-1:0] pix_buf[NPIX];

  initial begin
    forever begin
      @(posedge clk or negedge n_rst);
      if (!n_rst) begin
        m_prev = 1'b0; m_active = 1'b0; m_done = 1'b0; m_ovr = 1'b0; m_n = 0;
        m_cur.delete(); m_q.delete();
      end else begin : step_model
        bit tk, pop;
        logic [WW+1:0] w;
        tk = (flag_pixel != m_prev);
        m_prev = flag_pixel;
        pop = (m_q.size() > 0) && bus.out_ready;
        if (m_done) begin
          if (m_q.size() == 0) m_done = 1'b0;
        end else if (m_active) begin
          if (tk) begin
            m_cur.push_back(pixel_in);
            m_n++;
            if (m_cur.size() == PPW) begin
              w[WW-1:0] = {m_cur[3], m_cur[2], m_cur[1], m_cur[0]};
              w[WW]     = ((m_n % H) == 0);
              w[WW+1]   = (m_n == NPIX);
              m_cur.delete();
              if (pop) begin
                void'(m_q.pop_front());
                pop = 1'b0;
              end
              if (m_q.size() < 2) m_q.push_back(w);
              else m_ovr = 1'b1;
              if (m_n == NPIX) begin
                m_active = 1'b0;
                m_done = 1'b1;
              end
            end
          end
        end else if (start_frame) begin
          m_active = 1'b1; m_n = 0; m_ovr = 1'b0; m_cur.delete();
        end
        if (pop) void'(m_q.pop_front());
      end
    end
  end

  // Per-cycle scoreboard, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      n_cmp++;
      if (bus.out_valid !== (m_q.size() > 0)) begin
        n_err++;
        if (n_err < 40) $display("FAIL out_valid t=%0t: got %b want %b", $time, bus.out_valid,
                                 m_q.size() > 0);
      end
      if (m_q.size() > 0) begin
        n_cmp++;
        if ({bus.out_eof, bus.out_eol, bus.out_data} !== m_q[0]) begin
          n_err++;
          if (n_err < 40) $display("FAIL head_word t=%0t: got %h want %h", $time,
                                   {bus.out_eof, bus.out_eol, bus.out_data}, m_q[0]);
        end
      end
      n_cmp++;
      if (busy !== (m_active || m_done)) begin
        n_err++;
        if (n_err < 40) $display("FAIL busy t=%0t: got %b want %b", $time, busy,
                                 m_active || m_done);
      end
      n_cmp++;
      if (frame_done !== (m_done && m_q.size() == 0)) begin
        n_err++;
        if (n_err < 40) $display("FAIL frame_done t=%0t: got %b want %b", $time, frame_done,
                                 m_done && m_q.size() == 0);
      end
      n_cmp++;
      if (overrun !== m_ovr) begin
        n_err++;
        if (n_err < 40) $display("FAIL overrun t=%0t: got %b want %b", $time, overrun, m_ovr);
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1)
        rx.push_back({bus.out_eof, bus.out_eol, bus.out_data});
      if (frame_done === 1'b1) fd_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [WW+1:0] exp_word(input int k);
    int b;
    b = k * PPW;
    return {(b + PPW) == NPIX, ((b + PPW) % H) == 0,
            pix_buf[b+3], pix_buf[b+2], pix_buf[b+1], pix_buf[b]};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    start_frame = 1'b0;
    bus.out_ready = 1'b0;
    step(2);
    n_rst = 1'b1;
    step(2);
    rx.delete();
    fd_cnt = 0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < NPIX; i++) pix_buf[i] = PW'($urandom_range(0, 255));
  endtask

  task automatic pulse_start();
    start_frame = 1'b1;
    step(1);
    start_frame = 1'b0;
  endtask

  task automatic drive_pixel(input int i);
    pixel_in = pix_buf[i];
    flag_pixel = ~flag_pixel;
    step(4);
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 300) begin
      step(1);
      k++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, want 0", name, busy, k);
    end
    step(2);
  endtask

  task automatic check_words(input string name, input int n_exp);
    n_cmp++;
    if (rx.size() != n_exp) begin
      n_err++;
      $display("FAIL %s_count: got %0d words want %0d", name, rx.size(), n_exp);
    end else begin
      for (int k = 0; k < n_exp; k++) begin
        n_cmp++;
        if (rx[k] !== exp_word(k)) begin
          n_err++;
          $display("FAIL %s_word%0d: got %h want %h", name, k, rx[k], exp_word(k));
        end
      end
    end
  endtask

  task automatic check_frame_done(input string name);
    n_cmp++;
    if (fd_cnt != 1) begin
      n_err++;
      $display("FAIL %s_frame_done: got %0d pulses want 1", name, fd_cnt);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({bus.out_valid, bus.out_data, bus.out_eol, bus.out_eof, busy, frame_done, overrun}
        !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: valid=%b data=%h eol=%b eof=%b busy=%b fd=%b ovr=%b want 0",
               bus.out_valid, bus.out_data, bus.out_eol, bus.out_eof, busy, frame_done, overrun);
    end
    fill_random();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) drive_pixel(i);
    n_cmp++;
    if (rx.size() != 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_ticks: got %0d words busy=%b want 0 words busy=0", rx.size(), busy);
    end
    // Ticks seen in IDLE must not disturb the position of the next frame.
    fill_random();
    pulse_start();
    for (int i = 0; i < NPIX; i++) drive_pixel(i);
    wait_idle("idle_then_frame");
    check_words("idle_then_frame", 4);
  endtask

  task automatic test_basic_frame();
    logic [WW+1:0] want[4];
    want[0] = {2'b00, 32'h04030201};
    want[1] = {2'b01, 32'h08070605};
    want[2] = {2'b00, 32'h0C0B0A09};
    want[3] = {2'b11, 32'h100F0E0D};
    do_reset();
    for (int i = 0; i < NPIX; i++) pix_buf[i] = PW'(i + 1);
    bus.out_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < NPIX; i++) drive_pixel(i);
    wait_idle("basic");
    n_cmp++;
    if (rx.size() != 4) begin
      n_err++;
      $display("FAIL basic_count: got %0d words want 4", rx.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (rx[k] !== want[k]) begin
          n_err++;
          $display("FAIL basic_word%0d: got %h want %h", k, rx[k], want[k]);
        end
      end
    end
    check_frame_done("basic");
  endtask

  task automatic test_backpressure();
    do_reset();
    fill_random();
    pulse_start();
    for (int i = 0; i < NPIX; i++) drive_pixel(i);
    step(4);
    n_cmp++;
    if (overrun !== 1'b1 || bus.out_valid !== 1'b1 || rx.size() != 0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL stall_state: ovr=%b valid=%b words=%0d busy=%b want 1 1 0 1",
               overrun, bus.out_valid, rx.size(), busy);
    end
    bus.out_ready = 1'b1;
    wait_idle("stall");
    check_words("stall", 2);
    check_frame_done("stall");
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_err++;
      $display("FAIL stall_sticky: overrun=%b want 1", overrun);
    end
  endtask

  task automatic test_full_with_pop();
    do_reset();
    fill_random();
    pulse_start();
    for (int i = 0; i < 11; i++) drive_pixel(i);
    bus.out_ready = 1'b1;  // ready coincides with the tick completing word 3
    for (int i = 11; i < NPIX; i++) drive_pixel(i);
    wait_idle("full_pop");
    check_words("full_pop", 4);
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_err++;
      $display("FAIL full_pop_overrun: got %b want 0", overrun);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    fill_random();
    bus.out_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 6; i++) drive_pixel(i);
    n_rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.out_valid, bus.out_data, bus.out_eol, bus.out_eof, busy, frame_done, overrun}
        !== '0) begin
      n_err++;
      $display("FAIL midreset_outputs: valid=%b data=%h busy=%b fd=%b ovr=%b want 0",
               bus.out_valid, bus.out_data, busy, frame_done, overrun);
    end
    step(1);
    n_rst = 1'b1;
    step(2);
    rx.delete();
    fd_cnt = 0;
    fill_random();
    pulse_start();
    for (int i = 0; i < NPIX; i++) drive_pixel(i);
    wait_idle("midreset");
    check_words("midreset", 4);
    check_frame_done("midreset");
  endtask

  task automatic test_restart_ignored();
    do_reset();
    fill_random();
    bus.out_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 5; i++) drive_pixel(i);
    pulse_start();
    for (int i = 5; i < NPIX; i++) drive_pixel(i);
    wait_idle("restart");
    check_words("restart", 4);
    check_frame_done("restart");
  endtask

  initial begin
    bus.out_ready = 1'b0;
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_full_with_pop();
    test_reset_mid_frame();
    test_restart_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
